uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo.sv | 109 ++++++++++
 tb/tb_uart_rx_fifo.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Purpose  : Receive-side byte FIFO that captures one byte per rx_done pulse
//            and delivers bytes to a consumer with a one-cycle read latency.
// Revision : 1.0
// ============================================================================
module uart_rx_fifo #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic              rx_done,
   input  logic [DATA_W-1:0] rx_data,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W:0]   count,
   output logic              overflow,
   input  logic              ovf_clr
);

   localparam int              c_DEPTH    = 1 << ADDR_W;
   localparam logic [ADDR_W:0] c_FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

   logic [DATA_W-1:0] r_mem [0:c_DEPTH-1];

   logic              r_rx_done_d;
   logic [ADDR_W-1:0] r_wr_ptr;
   logic [ADDR_W-1:0] r_rd_ptr;
   logic [ADDR_W:0]   r_count;
   logic              r_full;
   logic              r_empty;
   logic              r_overflow;
   logic [DATA_W-1:0] r_rd_data;
   logic              r_rd_valid;

   logic              w_wr;
   logic              w_rd_acc;
   logic              w_wr_acc;
   logic              w_drop;
   logic [ADDR_W:0]   w_count_nxt;

   // A full FIFO still accepts a write when a read frees a slot in the same cycle.
   assign w_wr     = rx_done & ~r_rx_done_d;
   assign w_rd_acc = rd_en & ~r_empty;
   assign w_wr_acc = w_wr & (~r_full | w_rd_acc);
   assign w_drop   = w_wr & r_full & ~w_rd_acc;

   always_comb begin
      w_count_nxt = r_count;
      if (w_wr_acc && !w_rd_acc) begin
         w_count_nxt = r_count + 1'b1;
      end else if (!w_wr_acc && w_rd_acc) begin
         w_count_nxt = r_count - 1'b1;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (w_wr_acc) begin
         r_mem[r_wr_ptr] <= rx_data;
      end
   end

   // rx_done_d resets high so a level already present at release is not a new byte.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         r_rx_done_d <= 1'b1;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_full      <= 1'b0;
         r_empty     <= 1'b1;
         r_overflow  <= 1'b0;
         r_rd_data   <= '0;
         r_rd_valid  <= 1'b0;
      end else begin
         r_rx_done_d <= rx_done;
         r_rd_valid  <= w_rd_acc;
         r_count     <= w_count_nxt;
         r_full      <= (w_count_nxt == c_FULL_CNT);
         r_empty     <= (w_count_nxt == '0);
         if (w_wr_acc) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_rd_acc) begin
            r_rd_ptr  <= r_rd_ptr + 1'b1;
            r_rd_data <= r_mem[r_rd_ptr];
         end
         if (w_drop) begin
            r_overflow <= 1'b1;
         end else if (ovf_clr) begin
            r_overflow <= 1'b0;
         end
      end
   end

   assign rd_data  = r_rd_data;
   assign rd_valid = r_rd_valid;
   assign full     = r_full;
   assign empty    = r_empty;
   assign count    = r_count;
   assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_fifo
// Purpose  : Self-checking bench for uart_rx_fifo against a queue-based model.
// Revision : 1.0
// ============================================================================
module tb_uart_rx_fifo;

   localparam int c_DEPTH = 256;

   logic       sys_clk = 1'b0;
   logic       sys_rst;
   logic       rx_done;
   logic [7:0] rx_data;
   logic       rd_en;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic       full;
   logic       empty;
   logic [8:0] count;
   logic       overflow;
   logic       ovf_clr;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   // Reference model: byte queue plus the observable output state.
   logic [7:0] m_q [$];
   bit         m_prev;
   bit         m_ovf;
   logic [7:0] m_data;
   bit         m_valid;

   uart_rx_fifo #(.DATA_W(8), .ADDR_W(8)) dut (
      .sys_clk  (sys_clk),
      .sys_rst  (sys_rst),
      .rx_done  (rx_done),
      .rx_data  (rx_data),
      .rd_en    (rd_en),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .full     (full),
      .empty    (empty),
      .count    (count),
      .overflow (overflow),
      .ovf_clr  (ovf_clr)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   task automatic check_all();
      chk("count",    {23'd0, count}, m_q.size());
      chk("empty",    {31'd0, empty}, (m_q.size() == 0) ? 1 : 0);
      chk("full",     {31'd0, full},  (m_q.size() == c_DEPTH) ? 1 : 0);
      chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
      chk("rd_valid", {31'd0, rd_valid}, {31'd0, m_valid});
      chk("rd_data",  {24'd0, rd_data}, {24'd0, m_data});
   endtask

   task automatic model_reset();
      m_q.delete();
      m_prev  = 1'b1;
      m_ovf   = 1'b0;
      m_data  = 8'h00;
      m_valid = 1'b0;
   endtask

   // One clock: evaluate the model on the current inputs, then compare after the edge.
   task automatic step();
      bit wr, rd, drop;
      wr     = rx_done && !m_prev;
      m_prev = rx_done;
      rd     = rd_en && (m_q.size() != 0);
      drop   = 1'b0;
      m_valid = rd;
      if (rd) m_data = m_q.pop_front();
      if (wr) begin
         if (m_q.size() < c_DEPTH) m_q.push_back(rx_data);
         else drop = 1'b1;
      end
      if (drop) m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
      @(posedge sys_clk);
      #1;
      cyc++;
      check_all();
   endtask

   task automatic push_byte(input logic [7:0] d);
      rx_data = d;
      rx_done = 1'b1;
      step();
      rx_done = 1'b0;
      step();
   endtask

   task automatic pop_n(input int n);
      rd_en = 1'b1;
      repeat (n) step();
      rd_en = 1'b0;
   endtask

   task automatic do_reset();
      sys_rst = 1'b1;
      model_reset();
      #1;
      check_all();
      @(posedge sys_clk);
      #1;
      sys_rst = 1'b0;
   endtask

   initial begin
      sys_rst = 1'b1;
      rx_done = 1'b0;
      rx_data = 8'h00;
      rd_en   = 1'b0;
      ovf_clr = 1'b0;
      model_reset();
      #2;
      check_all();
      @(posedge sys_clk);
      #1;
      sys_rst = 1'b0;
      step();

      // Long rx_done level yields exactly one byte
      rx_data = 8'hA5;
      rx_done = 1'b1;
      repeat (200) step();
      rx_done = 1'b0;
      step();
      chk("long_done_count", {23'd0, count}, 1);
      pop_n(1);
      chk("long_done_data", {24'd0, rd_data}, 32'hA5);
      chk("long_done_valid", {31'd0, rd_valid}, 1);
      step();

      // Fill to capacity, overflow on the 257th byte, drain in order
      for (int i = 0; i < 256; i++) push_byte(i[7:0]);
      chk("fill_count", {23'd0, count}, 256);
      chk("fill_full", {31'd0, full}, 1);
      push_byte(8'h55);
      chk("drop_ovf", {31'd0, overflow}, 1);
      chk("drop_count", {23'd0, count}, 256);
      pop_n(256);
      chk("drain_last", {24'd0, rd_data}, 32'hFF);
      step();
      ovf_clr = 1'b1;
      step();
      ovf_clr = 1'b0;
      chk("ovf_cleared", {31'd0, overflow}, 0);

      // Pointer wrap past the top of the array
      for (int i = 0; i < 200; i++) push_byte(8'(i * 3));
      pop_n(200);
      for (int i = 0; i < 100; i++) push_byte(8'(i + 8'h40));
      pop_n(100);
      step();
      chk("wrap_empty_count", {23'd0, count}, 0);

      // Full with simultaneous write and read
      for (int i = 0; i < 256; i++) push_byte(8'(255 - i));
      rx_data = 8'h77;
      rx_done = 1'b1;
      rd_en   = 1'b1;
      step();
      chk("fullrw_data", {24'd0, rd_data}, 32'hFF);
      rx_done = 1'b0;
      rd_en   = 1'b0;
      step();
      chk("fullrw_count", {23'd0, count}, 256);
      chk("fullrw_ovf", {31'd0, overflow}, 0);
      pop_n(256);
      chk("fullrw_tail", {24'd0, rd_data}, 32'h77);
      step();

      // Reads on empty are ignored; write+read on empty only writes
      pop_n(10);
      rx_data = 8'h3C;
      rx_done = 1'b1;
      rd_en   = 1'b1;
      step();
      chk("empty_rw_valid", {31'd0, rd_valid}, 0);
      rx_done = 1'b0;
      rd_en   = 1'b0;
      step();
      chk("empty_rw_count", {23'd0, count}, 1);
      pop_n(1);
      step();

      // Reset mid-operation discards contents
      for (int i = 0; i < 10; i++) push_byte(8'(i + 8'hC0));
      do_reset();
      chk("rst_count", {23'd0, count}, 0);
      step();

      // rx_done held high across reset release produces no write
      rx_data = 8'hEE;
      rx_done = 1'b1;
      step();
      do_reset();
      repeat (3) step();
      chk("rst_held_done", {23'd0, count}, 0);
      rx_done = 1'b0;
      step();

      // Clear coincident with a drop leaves overflow set
      for (int i = 0; i < 256; i++) push_byte(8'(i ^ 8'h5A));
      rx_data = 8'h99;
      rx_done = 1'b1;
      ovf_clr = 1'b1;
      step();
      chk("ovf_set_wins", {31'd0, overflow}, 1);
      rx_done = 1'b0;
      ovf_clr = 1'b0;
      step();
      pop_n(256);
      do_reset();
      step();

      // Randomised phases: fill-biased, drain-biased, balanced
      for (int ph = 0; ph < 6; ph++) begin
         int p_wr, p_rd;
         case (ph % 3)
            0:       begin p_wr = 90; p_rd = 10; end
            1:       begin p_wr = 10; p_rd = 90; end
            default: begin p_wr = 50; p_rd = 50; end
         endcase
         for (int c = 0; c < 700; c++) begin
            if (rx_done) begin
               if ($urandom_range(99) < 50) rx_done = 1'b0;
            end else begin
               rx_data = 8'($urandom);
               if ($urandom_range(99) < p_wr) rx_done = 1'b1;
            end
            rd_en   = ($urandom_range(99) < p_rd);
            ovf_clr = ($urandom_range(15) == 0);
            step();
         end
      end
      rx_done = 1'b0;
      rd_en   = 1'b0;
      ovf_clr = 1'b0;
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
